// File: rtl/pc_sequencer_if.sv
// Control and fetch-address bundle between decode/execute and the PC sequencer.
interface pc_sequencer_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    logic        trap_req;
    logic        trap_ack;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  state;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               halt, resume, trap_req,
        input  trap_ack, epc, pc, pc_valid, state
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               halt, resume, trap_req,
        output trap_ack, epc, pc, pc_valid, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the word-addressed PC and picks the next fetch address.
// Optional trap support (trap vector, epc, trap_ack) is compiled in with `define PC_TRAP_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'd0,
    parameter logic [31:0] TRAP_VECTOR  = 32'd64
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.slave   bus
);
    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic [PC_W-1:0]   epc_q, epc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              trap_req_en;
    logic              trap_take;

`ifdef PC_TRAP_EN
    assign trap_req_en = bus.trap_req;
`else
    logic unused_trap;
    assign trap_req_en = 1'b0;
    assign unused_trap = ^{bus.trap_req, TRAP_VECTOR};
`endif

    // Wraps silently at 32'hFFFFFFFF
    assign pc_inc = pc_q + PC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            pc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        trap_take = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            // Redirects outrank stall; stall only blocks the sequential increment
            ST_RUN: begin
                if (trap_req_en) begin
                    trap_take = 1'b1;
                    pc_d      = TRAP_VECTOR;
                    epc_d     = pc_q;
                end else if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (bus.jump) begin
                    pc_d = bus.jump_target;
                end else if (bus.branch_taken) begin
                    pc_d = bus.branch_target;
                end else if (!bus.stall) begin
                    pc_d = pc_inc;
                end
            end
            // Halted at pc; the interrupted instruction is the one after it
            ST_HALT: begin
                if (trap_req_en) begin
                    trap_take = 1'b1;
                    pc_d      = TRAP_VECTOR;
                    epc_d     = pc_inc;
                    state_d   = ST_RUN;
                end else if (bus.resume) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        pc_valid_d = (state_d == ST_RUN);
    end

    assign bus.pc       = pc_q;
    assign bus.epc      = epc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.state    = state_q;
    assign bus.trap_ack = trap_take;
endmodule
